fb_fetch_arbiter: RTL and testbench

- Owns the single-port framebuffer SRAM and shares it between two requesters: the VGA scanout's 32-pixel group fetches and the CPU's single-pixel read/write port.
- For each new (x_group, y) the VGA side requests, bursts 32 consecutive pixels into a staging buffer, then publishes them as one 32x12 buffer.
- Between VGA bursts, serves CPU accesses. VGA has priority at every access boundary.

---
 rtl/fb_fetch_arbiter_if.sv | 38 +++
 rtl/fb_fetch_arbiter.sv | 157 +++++++++++++++
 tb/tb_fb_fetch_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_fetch_arbiter_if.sv
// Framebuffer arbiter bus: VGA group-fetch port, CPU pixel port and SRAM port.
// The arbiter takes the slave view; requesters plus the SRAM sit on the master view.
interface fb_fetch_arbiter_if #(
    parameter int ADDR_W = 19
);
    logic              vga_fetch_en;
    logic [4:0]        vga_x_group;
    logic [8:0]        vga_y_val;
    logic [383:0]      vga_buf;
    logic              vga_buf_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [11:0]       cpu_wdata;
    logic              cpu_ack;
    logic [11:0]       cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_wdata;
    logic [11:0]       mem_rdata;

    modport slave (
        input  vga_fetch_en, vga_x_group, vga_y_val,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output vga_buf, vga_buf_valid, cpu_ack, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output vga_fetch_en, vga_x_group, vga_y_val,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  vga_buf, vga_buf_valid, cpu_ack, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_fetch_arbiter.sv
// Single-port framebuffer SRAM arbiter: 32-pixel VGA group bursts with priority, CPU pixel accesses in between.
// Optional FB_STALL_STATS_EN adds stat_cpu_stall, a saturating count of cycles the CPU waits.
module fb_fetch_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int GROUPS   = 20,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    fb_fetch_arbiter_if.slave bus
`ifdef FB_STALL_STATS_EN
    ,
    output logic [15:0]       stat_cpu_stall
`endif
);
    localparam int FB_SIZE = H_ACTIVE * V_ACTIVE;
    localparam int NPIX    = 32;

    typedef enum logic [2:0] {IDLE, VGA_BURST, VGA_DRAIN, CPU_RD, CPU_DONE} state_e;

    state_e                state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic                  pend_q, pend_d;
    logic [13:0]           pend_tag_q, pend_tag_d;
    logic                  tag_vld_q, tag_vld_d;
    logic [13:0]           tag_q, tag_d;
    logic [NPIX-2:0][11:0] stg_q;
    logic [NPIX*12-1:0]    buf_q, buf_d;
    logic                  bufv_q, bufv_d;
    logic [11:0]           rdata_q, rdata_d;

    logic [13:0] req_tag, sel_tag;
    logic        req_new, sel_vld, cpu_in_range;

    // Tag is {y, group}; a fresh request can start a burst in the same IDLE cycle it appears.
    assign req_tag      = {bus.vga_y_val, bus.vga_x_group};
    assign req_new      = bus.vga_fetch_en && (32'(bus.vga_x_group) < GROUPS) &&
                          (!tag_vld_q || (req_tag != tag_q));
    assign sel_vld      = req_new || pend_q;
    assign sel_tag      = req_new ? req_tag : pend_tag_q;
    assign cpu_in_range = 32'(bus.cpu_addr) < FB_SIZE;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        base_d        = base_q;
        pend_d        = pend_q;
        pend_tag_d    = pend_tag_q;
        tag_vld_d     = tag_vld_q;
        tag_d         = tag_q;
        buf_d         = buf_q;
        bufv_d        = 1'b0;
        rdata_d       = rdata_q;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cpu_ack   = 1'b0;

        if (req_new) begin
            tag_d      = req_tag;
            tag_vld_d  = 1'b1;
            pend_d     = 1'b1;
            pend_tag_d = req_tag;
        end

        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d = VGA_BURST;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    base_d  = ADDR_W'(int'(sel_tag[13:5]) * H_ACTIVE + int'(sel_tag[4:0]) * NPIX);
                end else if (bus.cpu_req) begin
                    state_d = CPU_RD;
                end
            end
            VGA_BURST: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = base_q + ADDR_W'(idx_q);
                idx_d        = idx_q + 5'd1;
                if (idx_q == 5'(NPIX - 1)) state_d = VGA_DRAIN;
            end
            VGA_DRAIN: begin
                // Whole buffer replaced in one edge so the consumer never sees a mix of groups.
                buf_d   = {bus.mem_rdata, stg_q};
                bufv_d  = 1'b1;
                state_d = IDLE;
            end
            CPU_RD: begin
                bus.mem_en    = cpu_in_range;
                bus.mem_we    = bus.cpu_we && cpu_in_range;
                bus.mem_addr  = cpu_in_range ? bus.cpu_addr : '0;
                bus.mem_wdata = cpu_in_range ? bus.cpu_wdata : '0;
                state_d       = CPU_DONE;
            end
            CPU_DONE: begin
                bus.cpu_ack = 1'b1;
                if (!bus.cpu_we) rdata_d = cpu_in_range ? bus.mem_rdata : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cpu_rdata     = rdata_d;
    assign bus.vga_buf       = buf_q;
    assign bus.vga_buf_valid = bufv_q;

    // Word for burst index i-1 arrives while index i is on the address bus.
    always_ff @(posedge clk) begin
        if (state_q == VGA_BURST && idx_q != 5'd0) stg_q[idx_q - 5'd1] <= bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            base_q     <= '0;
            pend_q     <= 1'b0;
            pend_tag_q <= '0;
            tag_vld_q  <= 1'b0;
            tag_q      <= '0;
            buf_q      <= '0;
            bufv_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            pend_q     <= pend_d;
            pend_tag_q <= pend_tag_d;
            tag_vld_q  <= tag_vld_d;
            tag_q      <= tag_d;
            buf_q      <= buf_d;
            bufv_q     <= bufv_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef FB_STALL_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (bus.cpu_req && state_q != CPU_RD && state_q != CPU_DONE &&
                     stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stat_cpu_stall = stall_q;
`endif
endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Scoreboard bench for fb_fetch_arbiter: driver pushes expected buffers/read data computed from a
// flat pixel-memory model; a monitor pops on every vga_buf_valid / cpu_ack and compares data and cycle.
module tb_fb_fetch_arbiter;
    localparam int FB = 640 * 480;

    typedef struct { logic [383:0] d; int due; } vexp_t;
    typedef struct { logic [11:0]  d; int due; } cexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fb_fetch_arbiter_if bus ();
`ifdef FB_STALL_STATS_EN
    logic [15:0] stall;
`endif

    fb_fetch_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FB_STALL_STATS_EN
        ,
        .stat_cpu_stall (stall)
`endif
    );

    int nvec = 0, nerr = 0;
    int cyc = 0, mem_en_cnt = 0, oor_hits = 0;
    int nvga = 0, ncpu = 0;
    vexp_t vq[$];
    cexp_t cq[$];

    // SRAM: unwritten words read back as addr[11:0]
    logic [11:0] sram      [0:FB-1];
    bit          sram_mask [0:FB-1];
    logic [11:0] ref_mem   [0:FB-1];
    bit          ref_mask  [0:FB-1];

    bit   tag_vld = 1'b0;
    int   tag_y = 0, tag_g = 0;
    logic [11:0] last_rd = 12'h000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            mem_en_cnt <= mem_en_cnt + 1;
            if (int'(bus.mem_addr) < FB) begin
                if (bus.mem_we) begin
                    sram[bus.mem_addr]      <= bus.mem_wdata;
                    sram_mask[bus.mem_addr] <= 1'b1;
                end else begin
                    bus.mem_rdata <= sram_mask[bus.mem_addr] ? sram[bus.mem_addr] : 12'(bus.mem_addr);
                end
            end else begin
                oor_hits <= oor_hits + 1;
            end
        end
    end

    function automatic logic [11:0] ref_rd(int a);
        return ref_mask[a] ? ref_mem[a] : 12'(a);
    endfunction

    // Monitor
    initial begin
        vexp_t ve;
        cexp_t ce;
        forever begin
            @(posedge clk);
            #1;
            if (bus.vga_buf_valid === 1'b1) begin
                nvga++;
                nvec++;
                if (vq.size() == 0) begin
                    nerr++;
                    $display("FAIL vga_unexpected: valid pulse at cycle %0d, none required", cyc);
                end else begin
                    ve = vq.pop_front();
                    if (bus.vga_buf !== ve.d || (ve.due >= 0 && cyc != ve.due)) begin
                        nerr++;
                        $display("FAIL vga_buf: got %h at cycle %0d, required %h at cycle %0d",
                                 bus.vga_buf, cyc, ve.d, ve.due);
                    end
                end
            end
            if (bus.cpu_ack === 1'b1) begin
                ncpu++;
                nvec++;
                if (cq.size() == 0) begin
                    nerr++;
                    $display("FAIL cpu_unexpected: ack at cycle %0d, none required", cyc);
                end else begin
                    ce = cq.pop_front();
                    if (bus.cpu_rdata !== ce.d || (ce.due >= 0 && cyc != ce.due)) begin
                        nerr++;
                        $display("FAIL cpu_rdata: got %h at cycle %0d, required %h at cycle %0d",
                                 bus.cpu_rdata, cyc, ce.d, ce.due);
                    end
                end
            end
        end
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vga_set(bit en, int y, int g, int due_lat);
        vexp_t ve;
        bus.vga_fetch_en = en;
        bus.vga_y_val    = 9'(y);
        bus.vga_x_group  = 5'(g);
        if (en && g < 20 && (!tag_vld || y != tag_y || g != tag_g)) begin
            for (int i = 0; i < 32; i++) ve.d[12*i +: 12] = ref_rd(y * 640 + g * 32 + i);
            ve.due = (due_lat >= 0) ? cyc + due_lat : -1;
            vq.push_back(ve);
            tag_vld = 1'b1;
            tag_y   = y;
            tag_g   = g;
        end
    endtask

    task automatic cpu_op(bit we, int addr, logic [11:0] wd, int due_lat, bit sync);
        cexp_t ce;
        bit    got;
        if (sync) @(negedge clk);
        if (we) begin
            if (addr < FB) begin
                ref_mem[addr]  = wd;
                ref_mask[addr] = 1'b1;
            end
            ce.d = last_rd;
        end else begin
            ce.d    = (addr < FB) ? ref_rd(addr) : 12'h000;
            last_rd = ce.d;
        end
        ce.due = (due_lat >= 0) ? cyc + due_lat : -1;
        cq.push_back(ce);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = 19'(addr);
        bus.cpu_wdata = wd;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = (bus.cpu_ack === 1'b1);
        end
        if (!got) begin
            nvec++;
            nerr++;
            $display("FAIL cpu_ack_timeout: no ack for addr %0d, required within 200 cycles", addr);
            cq.delete();
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic wait_vga_drain(int bound);
        for (int k = 0; k < bound && vq.size() != 0; k++) @(negedge clk);
        if (vq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL vga_timeout: %0d bursts outstanding, required 0", vq.size());
            vq.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, n0, sel, nops, a;
        bus.vga_fetch_en = 1'b0;
        bus.vga_x_group  = '0;
        bus.vga_y_val    = '0;
        bus.cpu_req      = 1'b0;
        bus.cpu_we       = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        tick(3);
        check("reset_vga_buf", 64'(|bus.vga_buf), 64'd0);
        check("reset_ctrl", 64'({bus.vga_buf_valid, bus.cpu_ack, bus.cpu_rdata, bus.mem_en,
                                 bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);
        rst = 1'b1;

        // Single group fetch, then held request must not re-fetch
        tick(1);
        e0 = mem_en_cnt;
        n0 = nvga;
        vga_set(1'b1, 2, 3, 34);
        tick(200);
        check("t1_valid_pulses", 64'(nvga - n0), 64'd1);
        check("t1_mem_reads", 64'(mem_en_cnt - e0), 64'd32);

        // CPU write then read-back
        cpu_op(1'b1, 1000, 12'hABC, 2, 1'b1);
        cpu_op(1'b0, 1000, 12'h000, 2, 1'b1);

        // Simultaneous VGA group and CPU read: burst first
        @(negedge clk);
        vga_set(1'b1, 5, 7, 34);
        cpu_op(1'b0, 2000, 12'h000, 36, 1'b0);
        tick(5);

        // Out-of-range CPU accesses
        e0 = mem_en_cnt;
        cpu_op(1'b0, 307200, 12'h000, 2, 1'b1);
        cpu_op(1'b1, 400000, 12'h555, 2, 1'b1);
        check("oor_no_mem_en", 64'(mem_en_cnt - e0), 64'd0);

        // Invalid group ignored
        tick(1);
        e0 = mem_en_cnt;
        n0 = nvga;
        vga_set(1'b1, 7, 20, -1);
        tick(50);
        check("grp20_no_mem_en", 64'(mem_en_cnt - e0), 64'd0);
        check("grp20_no_valid", 64'(nvga - n0), 64'd0);

        // Reset at burst word 15, then the held request fetches again
        tick(1);
        vga_set(1'b1, 10, 0, -1);
        tick(16);
        rst = 1'b0;
        vq.delete();
        cq.delete();
        tag_vld = 1'b0;
        last_rd = 12'h000;
        tick(2);
        check("rst_vga_buf_clear", 64'(|bus.vga_buf), 64'd0);
        check("rst_idle", 64'({bus.vga_buf_valid, bus.mem_en, bus.cpu_ack}), 64'd0);
        rst = 1'b1;
        vga_set(1'b1, 10, 0, 34);
        wait_vga_drain(100);

        // fetch_en drops mid-burst: burst still publishes; re-raising the same tag does nothing
        tick(1);
        vga_set(1'b1, 20, 4, 34);
        tick(5);
        bus.vga_fetch_en = 1'b0;
        wait_vga_drain(100);
        vga_set(1'b1, 20, 4, -1);
        tick(40);

        // Randomized mix
        for (int it = 0; it < 40; it++) begin
            tick(1);
            if ($urandom_range(0, 9) < 2 && tag_vld)
                vga_set(1'b1, tag_y, tag_g, -1);
            else
                vga_set(1'b1, int'($urandom_range(0, 399)), int'($urandom_range(0, 21)), -1);
            if ($urandom_range(0, 3) == 0) begin
                tick(3);
                bus.vga_fetch_en = 1'b0;
            end
            nops = int'($urandom_range(0, 6));
            for (int k = 0; k < nops; k++) begin
                sel = int'($urandom_range(0, 19));
                if (sel < 8) begin
                    a = 256000 + int'($urandom_range(0, 51199));
                    cpu_op(1'b1, a, 12'($urandom), -1, 1'b1);
                end else if (sel < 10) begin
                    a = FB + int'($urandom_range(0, 524287 - FB));
                    cpu_op(1'($urandom_range(0, 1)), a, 12'($urandom), -1, 1'b1);
                end else begin
                    a = int'($urandom_range(0, FB - 1));
                    cpu_op(1'b0, a, 12'h000, -1, 1'b1);
                end
            end
            wait_vga_drain(200);
        end

        tick(5);
        check("no_oor_sram_access", 64'(oor_hits), 64'd0);
        check("scoreboard_empty", 64'(vq.size() + cq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
